signal_phase_scheduler: RTL and testbench

Sequences a two-approach (NS/EW) intersection through green, yellow and all-red phases using a 1-second timebase derived from the 1 kHz system clock. Arbitrates pedestrian walk requests from both approaches and an emergency preempt input. Drives the per-direction light codes, walk strobes and a two-digit BCD countdown that feeds the segment encoder and display mux. Replaces the free-running 2-bit signal FSM in the traffic light top level.

---
 rtl/signal_phase_scheduler.sv | 175 +++++++++++++++++
 tb/tb_signal_phase_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/signal_phase_scheduler.sv
// Two-approach intersection phase sequencer with a 1 s timebase, pedestrian walk
// arbitration, cross-request gap-out, emergency preempt and a BCD countdown.
module signal_phase_scheduler #(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned T_GREEN     = 10,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned T_PED       = 6,
    parameter int unsigned T_GREEN_MIN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       preempt,
    output logic [2:0] phase,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [7:0] countdown,
    output logic       sec_tick
);

    typedef enum logic [2:0] {
        NS_GO   = 3'd0,
        NS_WARN = 3'd1,
        CLR_A   = 3'd2,
        EW_GO   = 3'd3,
        EW_WARN = 3'd4,
        CLR_B   = 3'd5,
        PREEMPT = 3'd6
    } phase_t;

    if (TICK_DIV < 2 || TICK_DIV > 65535 ||
        T_GREEN < 1 || T_GREEN > 99 || T_YELLOW < 1 || T_YELLOW > 99 ||
        T_ALLRED < 1 || T_ALLRED > 99 || T_PED < 1 || T_PED > 99 ||
        T_GREEN_MIN < 1 || T_GREEN_MIN > 99 || T_GREEN_MIN > T_GREEN) begin : g_param_check
        $error("signal_phase_scheduler: illegal parameter set");
    end

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [6:0]  D_GREEN   = 7'(T_GREEN);
    localparam logic [6:0]  D_YELLOW  = 7'(T_YELLOW);
    localparam logic [6:0]  D_ALLRED  = 7'(T_ALLRED);
    localparam logic [6:0]  D_GMIN    = 7'(T_GREEN_MIN);
    localparam logic [6:0]  D_WALK    = 7'((T_PED > T_GREEN) ? T_PED : T_GREEN);

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        tens = 4'(v / 7'd10);
        return {tens, 4'(v - 7'(tens) * 7'd10)};
    endfunction

    phase_t      phase_q, phase_d, next_p;
    logic [6:0]  rem_q, rem_d;
    logic [15:0] presc_q, presc_d;
    logic        sec_tick_q;
    logic        walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
    logic        pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
    logic        pend_ns_eff, pend_ew_eff;
    logic        advance;
    logic [1:0]  ns_light_d, ew_light_d;

    assign phase    = phase_q;
    assign walk_ns  = walk_ns_q;
    assign walk_ew  = walk_ew_q;
    assign sec_tick = sec_tick_q;

    always_comb begin
        presc_d     = (presc_q == TICK_LAST) ? '0 : presc_q + 16'd1;
        phase_d     = phase_q;
        next_p      = phase_q;
        rem_d       = rem_q;
        walk_ns_d   = walk_ns_q;
        walk_ew_d   = walk_ew_q;
        pend_ns_eff = pend_ns_q | ped_req_ns;
        pend_ew_eff = pend_ew_q | ped_req_ew;
        pend_ns_d   = pend_ns_eff;
        pend_ew_d   = pend_ew_eff;
        advance     = 1'b0;
        ns_light_d  = 2'b00;
        ew_light_d  = 2'b00;

        if (phase_q == PREEMPT) begin
            if (!preempt) begin
                advance = 1'b1;
                next_p  = CLR_B;
            end
        end else if (sec_tick_q && rem_q == 7'd1) begin
            advance = 1'b1;
            case (phase_q)
                NS_GO:   next_p = NS_WARN;
                NS_WARN: next_p = preempt ? PREEMPT : CLR_A;
                CLR_A:   next_p = preempt ? PREEMPT : EW_GO;
                EW_GO:   next_p = EW_WARN;
                EW_WARN: next_p = preempt ? PREEMPT : CLR_B;
                default: next_p = preempt ? PREEMPT : NS_GO;
            endcase
        end

        // Transition beats forced-rem updates, which beat the tick decrement.
        if (advance) begin
            phase_d   = next_p;
            walk_ns_d = 1'b0;
            walk_ew_d = 1'b0;
            case (next_p)
                NS_GO: begin
                    rem_d     = pend_ns_eff ? D_WALK : D_GREEN;
                    walk_ns_d = pend_ns_eff;
                    pend_ns_d = 1'b0;
                end
                EW_GO: begin
                    rem_d     = pend_ew_eff ? D_WALK : D_GREEN;
                    walk_ew_d = pend_ew_eff;
                    pend_ew_d = 1'b0;
                end
                NS_WARN, EW_WARN: rem_d = D_YELLOW;
                PREEMPT:          rem_d = rem_q;
                default:          rem_d = D_ALLRED;
            endcase
        end else if (phase_q == NS_GO || phase_q == EW_GO) begin
            if (preempt) begin
                rem_d     = 7'd1;
                walk_ns_d = 1'b0;
                walk_ew_d = 1'b0;
            end else if (rem_q > D_GMIN &&
                         ((phase_q == NS_GO) ? (pend_ew_eff && !walk_ns_q)
                                             : (pend_ns_eff && !walk_ew_q))) begin
                rem_d = D_GMIN;
            end else if (sec_tick_q) begin
                rem_d = rem_q - 7'd1;
            end
        end else if (phase_q != PREEMPT && sec_tick_q) begin
            rem_d = rem_q - 7'd1;
        end

        case (phase_d)
            NS_GO:   ns_light_d = 2'b10;
            NS_WARN: ns_light_d = 2'b01;
            EW_GO:   ew_light_d = 2'b10;
            EW_WARN: ew_light_d = 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            phase_q    <= CLR_B;
            rem_q      <= D_ALLRED;
            walk_ns_q  <= 1'b0;
            walk_ew_q  <= 1'b0;
            pend_ns_q  <= 1'b0;
            pend_ew_q  <= 1'b0;
            ns_light   <= 2'b00;
            ew_light   <= 2'b00;
            countdown  <= to_bcd(D_ALLRED);
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= (presc_d == TICK_LAST);
            phase_q    <= phase_d;
            rem_q      <= rem_d;
            walk_ns_q  <= walk_ns_d;
            walk_ew_q  <= walk_ew_d;
            pend_ns_q  <= pend_ns_d;
            pend_ew_q  <= pend_ew_d;
            ns_light   <= ns_light_d;
            ew_light   <= ew_light_d;
            countdown  <= (phase_d == PREEMPT) ? 8'h00 : to_bcd(rem_d);
        end
    end

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Directed bench for signal_phase_scheduler: a timed vector table for the basic
// cycle, then hand-written gap-out, preempt, held-request and reset sequences.
module tb_signal_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_req_ns = 1'b0;
    logic       ped_req_ew = 1'b0;
    logic       preempt = 1'b0;
    logic [2:0] phase;
    logic [1:0] ns_light, ew_light;
    logic       walk_ns, walk_ew;
    logic [7:0] countdown;
    logic       sec_tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int now    = 0;

    signal_phase_scheduler #(
        .TICK_DIV(4), .T_GREEN(10), .T_YELLOW(3), .T_ALLRED(1), .T_PED(12), .T_GREEN_MIN(4)
    ) dut (
        .clk(clk), .rst(rst), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .preempt(preempt), .phase(phase), .ns_light(ns_light), .ew_light(ew_light),
        .walk_ns(walk_ns), .walk_ew(walk_ew), .countdown(countdown), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic       rn, re, pre;
        logic [2:0] ph;
        logic [1:0] ns, ew;
        logic       wn, we;
        logic [7:0] cd;
        logic       tk;
    } vec_t;

    vec_t tv[18];

    function automatic vec_t mk(int t, logic rn, logic re, logic pre, logic [2:0] ph,
                                logic [1:0] ns, logic [1:0] ew, logic wn, logic we,
                                logic [7:0] cd, logic tk);
        vec_t v;
        v.t = t; v.rn = rn; v.re = re; v.pre = pre; v.ph = ph; v.ns = ns; v.ew = ew;
        v.wn = wn; v.we = we; v.cd = cd; v.tk = tk;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, now);
        end
    endtask

    task automatic wait_phase(input logic [2:0] p, input string name);
        int k = 0;
        while (phase !== p && k < 300) begin
            step();
            k++;
        end
        chk(name, 32'(phase), 32'(p));
    endtask

    task automatic wait_cd(input logic [2:0] p, input logic [7:0] cd, input string name);
        int k = 0;
        while (!(phase === p && countdown === cd) && k < 300) begin
            step();
            k++;
        end
        chk(name, 32'(countdown), 32'(cd));
    endtask

    // Counts sec_tick pulses seen while the phase stays at p, from the current sample on.
    task automatic count_ticks(input logic [2:0] p, output int n);
        int k = 0;
        n = 0;
        while (phase === p && k < 300) begin
            if (sec_tick === 1'b1) n++;
            step();
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //            t    rn    re    pre   ph    ns     ew     wn    we    cd     tk
        tv[0]  = mk(  0, 1'b0, 1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 8'h01, 1'b0);
        tv[1]  = mk(  3, 1'b0, 1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 8'h01, 1'b1);
        tv[2]  = mk(  4, 1'b0, 1'b0, 1'b0, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 8'h10, 1'b0);
        tv[3]  = mk(  7, 1'b0, 1'b0, 1'b0, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 8'h10, 1'b1);
        tv[4]  = mk(  8, 1'b0, 1'b0, 1'b0, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 8'h09, 1'b0);
        tv[5]  = mk( 43, 1'b0, 1'b0, 1'b0, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 8'h01, 1'b1);
        tv[6]  = mk( 44, 1'b0, 1'b0, 1'b0, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0, 8'h03, 1'b0);
        tv[7]  = mk( 55, 1'b0, 1'b0, 1'b0, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0, 8'h01, 1'b1);
        tv[8]  = mk( 56, 1'b0, 1'b0, 1'b0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 8'h01, 1'b0);
        tv[9]  = mk( 59, 1'b0, 1'b0, 1'b0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 8'h01, 1'b1);
        tv[10] = mk( 60, 1'b1, 1'b0, 1'b0, 3'd3, 2'b00, 2'b10, 1'b0, 1'b0, 8'h10, 1'b0);
        // NS request during EW_GO also gaps EW green out to the 4 s floor.
        tv[11] = mk( 61, 1'b0, 1'b0, 1'b0, 3'd3, 2'b00, 2'b10, 1'b0, 1'b0, 8'h04, 1'b0);
        tv[12] = mk( 75, 1'b0, 1'b0, 1'b0, 3'd3, 2'b00, 2'b10, 1'b0, 1'b0, 8'h01, 1'b1);
        tv[13] = mk( 76, 1'b0, 1'b0, 1'b0, 3'd4, 2'b00, 2'b01, 1'b0, 1'b0, 8'h03, 1'b0);
        tv[14] = mk( 88, 1'b0, 1'b0, 1'b0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 8'h01, 1'b0);
        tv[15] = mk( 92, 1'b0, 1'b0, 1'b0, 3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 8'h12, 1'b0);
        tv[16] = mk(139, 1'b0, 1'b0, 1'b0, 3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 8'h01, 1'b1);
        tv[17] = mk(140, 1'b0, 1'b0, 1'b0, 3'd1, 2'b01, 2'b00, 1'b0, 1'b0, 8'h03, 1'b0);

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        now = 0;
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            while (now < tv[i].t) step();
            chk($sformatf("v%0d.phase", i), 32'(phase), 32'(tv[i].ph));
            chk($sformatf("v%0d.ns_light", i), 32'(ns_light), 32'(tv[i].ns));
            chk($sformatf("v%0d.ew_light", i), 32'(ew_light), 32'(tv[i].ew));
            chk($sformatf("v%0d.walk_ns", i), 32'(walk_ns), 32'(tv[i].wn));
            chk($sformatf("v%0d.walk_ew", i), 32'(walk_ew), 32'(tv[i].we));
            chk($sformatf("v%0d.countdown", i), 32'(countdown), 32'(tv[i].cd));
            chk($sformatf("v%0d.sec_tick", i), 32'(sec_tick), 32'(tv[i].tk));
            ped_req_ns = tv[i].rn;
            ped_req_ew = tv[i].re;
            preempt    = tv[i].pre;
        end

        // Gap-out: EW request while NS_GO shows 9 s.
        wait_cd(3'd0, 8'h09, "gap.find_ns9");
        ped_req_ew = 1'b1;
        step();
        ped_req_ew = 1'b0;
        chk("gap.countdown", 32'(countdown), 32'h04);
        chk("gap.phase", 32'(phase), 32'd0);
        count_ticks(3'd0, n);
        chk("gap.ticks_to_warn", 32'(n), 32'd4);
        chk("gap.next_phase", 32'(phase), 32'd1);
        wait_phase(3'd3, "gap.ew_go");
        chk("gap.walk_ew", 32'(walk_ew), 32'd1);
        chk("gap.ew_cd", 32'(countdown), 32'h12);

        // Preempt in EW_GO at 7 s.
        wait_cd(3'd3, 8'h07, "pre.find_ew7");
        preempt = 1'b1;
        step();
        chk("pre.rem1", 32'(countdown), 32'h01);
        chk("pre.walk_cleared", 32'(walk_ew), 32'd0);
        chk("pre.still_go", 32'(phase), 32'd3);
        wait_phase(3'd4, "pre.ew_warn");
        count_ticks(3'd4, n);
        chk("pre.warn_ticks", 32'(n), 32'd3);
        chk("pre.phase", 32'(phase), 32'd6);
        chk("pre.ns_light", 32'(ns_light), 32'd0);
        chk("pre.ew_light", 32'(ew_light), 32'd0);
        chk("pre.countdown", 32'(countdown), 32'h00);
        repeat (8) step();
        chk("pre.hold", 32'(phase), 32'd6);
        chk("pre.hold_cd", 32'(countdown), 32'h00);
        preempt = 1'b0;
        step();
        chk("pre.clr_b", 32'(phase), 32'd5);
        chk("pre.clr_b_cd", 32'(countdown), 32'h01);
        count_ticks(3'd5, n);
        chk("pre.clr_ticks", 32'(n), 32'd1);
        chk("pre.ns_go", 32'(phase), 32'd0);
        chk("pre.ns_go_cd", 32'(countdown), 32'h10);

        // Request held across the NS_GO entry edge is served once.
        wait_phase(3'd5, "held.clr_b");
        ped_req_ns = 1'b1;
        wait_phase(3'd0, "held.ns_go");
        ped_req_ns = 1'b0;
        chk("held.walk_ns", 32'(walk_ns), 32'd1);
        chk("held.cd", 32'(countdown), 32'h12);
        wait_phase(3'd3, "held.ew_go");
        chk("held.ew_walk", 32'(walk_ew), 32'd0);
        chk("held.ew_cd", 32'(countdown), 32'h10);
        wait_phase(3'd0, "held.ns_go2");
        chk("held.no_walk", 32'(walk_ns), 32'd0);
        chk("held.ns_cd2", 32'(countdown), 32'h10);

        // Reset mid EW_WARN.
        wait_phase(3'd4, "rst.ew_warn");
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.phase", 32'(phase), 32'd5);
        chk("rst.countdown", 32'(countdown), 32'h01);
        chk("rst.ns_light", 32'(ns_light), 32'd0);
        chk("rst.ew_light", 32'(ew_light), 32'd0);
        chk("rst.walks", 32'({walk_ns, walk_ew}), 32'd0);
        chk("rst.sec_tick", 32'(sec_tick), 32'd0);
        step();
        step();
        chk("rst.presc_t2", 32'(sec_tick), 32'd0);
        step();
        chk("rst.presc_t3", 32'(sec_tick), 32'd1);
        step();
        chk("rst.ns_go", 32'(phase), 32'd0);
        chk("rst.ns_go_cd", 32'(countdown), 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
